// File: rtl/dmem_responder.sv
// Memory-side bus endpoint for the dcache controller: tags accepted LOAD/STORE commands
// combinationally and returns load data a fixed LATENCY cycles after acceptance.
module dmem_responder #(
  parameter int unsigned LATENCY         = 4,
  parameter int unsigned MAX_OUTSTANDING = 15,
  parameter int unsigned ADDR_BITS       = 13
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [63:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;
  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] MAX_CNT   = 4'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [3:0]  tag;
    logic [63:0] data;
  } stage_t;

  logic [63:0]          mem_q [DEPTH];
  logic [15:1]          busy_q, busy_d;
  logic [3:0]           cnt_q, cnt_d;
  stage_t [LATENCY-1:0] pipe_q, pipe_d;

  logic [ADDR_BITS-1:0] widx;
  logic [3:0]           free_tag;
  logic [3:0]           ret_tag;
  logic                 ret_valid;
  logic                 load_acc;
  logic                 store_acc;
  logic                 unused_addr;

  assign widx        = proc2mem_addr[ADDR_BITS+2:3];
  assign unused_addr = ^{proc2mem_addr[63:ADDR_BITS+3], proc2mem_addr[2:0]};

  assign ret_tag   = pipe_q[LATENCY-1].tag;
  assign ret_valid = (ret_tag != 4'd0);

  // A returning tag is still marked busy here, so it is only reissued next cycle.
  always_comb begin
    free_tag = '0;
    for (int unsigned t = 15; t >= 1; t--) begin
      if (!busy_q[t[3:0]]) free_tag = t[3:0];
    end
  end

  assign load_acc  = reset && (proc2mem_command == BUS_LOAD) &&
                     (free_tag != 4'd0) && (cnt_q < MAX_CNT);
  assign store_acc = reset && (proc2mem_command == BUS_STORE) && (free_tag != 4'd0);

  assign mem2proc_response = (load_acc || store_acc) ? free_tag : '0;
  assign mem2proc_tag      = ret_tag;
  assign mem2proc_data     = pipe_q[LATENCY-1].data;

  always_comb begin
    busy_d = busy_q;
    if (ret_valid) busy_d[ret_tag] = 1'b0;
    if (load_acc)  busy_d[free_tag] = 1'b1;
  end

  assign cnt_d = cnt_q + 4'(load_acc) - 4'(ret_valid);

  // Return path: stage 0 enters at acceptance, last stage drives the outputs.
  always_comb begin
    pipe_d = pipe_q << $bits(stage_t);
    pipe_d[0].tag  = load_acc ? free_tag : '0;
    pipe_d[0].data = load_acc ? mem_q[widx] : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
      pipe_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      pipe_q <= pipe_d;
    end
  end

  // Backing store is deliberately left untouched by reset.
  always_ff @(posedge clock) begin
    if (store_acc) mem_q[widx] <= proc2mem_data;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: queue-based reference model on the default
// instance plus directed checks on instances with long latency and a small load limit.
module tb_dmem_responder;

  localparam int L0 = 4;
  localparam int M0 = 15;
  localparam int AB = 13;
  localparam logic [1:0] NONE  = 2'h0;
  localparam logic [1:0] LOAD  = 2'h1;
  localparam logic [1:0] STORE = 2'h2;

  logic        clock = 1'b0;
  logic        rstn;
  logic [1:0]  c0, c1, c2;
  logic [63:0] a0, a1, a2, d0, d1, d2;
  logic [3:0]  r0, r1, r2, t0, t1, t2;
  logic [63:0] q0, q1, q2;

  always #5 clock = ~clock;

  dmem_responder u0 (
    .clock(clock), .reset(rstn), .proc2mem_command(c0), .proc2mem_addr(a0),
    .proc2mem_data(d0), .mem2proc_response(r0), .mem2proc_data(q0), .mem2proc_tag(t0));

  dmem_responder #(.LATENCY(15), .MAX_OUTSTANDING(15), .ADDR_BITS(13)) u1 (
    .clock(clock), .reset(rstn), .proc2mem_command(c1), .proc2mem_addr(a1),
    .proc2mem_data(d1), .mem2proc_response(r1), .mem2proc_data(q1), .mem2proc_tag(t1));

  dmem_responder #(.LATENCY(4), .MAX_OUTSTANDING(2), .ADDR_BITS(13)) u2 (
    .clock(clock), .reset(rstn), .proc2mem_command(c2), .proc2mem_addr(a2),
    .proc2mem_data(d2), .mem2proc_response(r2), .mem2proc_data(q2), .mem2proc_tag(t2));

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
    bit          known;
  } ld_t;

  ld_t         fly[$];
  logic [63:0] mmem [int];
  int          cyc;
  int          checks;
  int          errors;

  logic [3:0]  e_resp, e_tag;
  logic [63:0] e_data;
  bit          e_known;
  logic [1:0]  p_cmd;
  logic [63:0] p_addr, p_data;
  logic        p_rst;

  function automatic int widx(input logic [63:0] a);
    return int'((a >> 3) % (64'd1 << AB));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive0(input logic [1:0] cmd, input logic [63:0] addr,
                        input logic [63:0] data, input logic rst);
    int unsigned busy;
    c0 = cmd; a0 = addr; d0 = data; rstn = rst;
    p_cmd = cmd; p_addr = addr; p_data = data; p_rst = rst;
    e_tag = '0; e_data = '0; e_known = 1'b1; busy = 0;
    foreach (fly[i]) begin
      busy = busy | (32'd1 << fly[i].tag);
      if (fly[i].due == cyc) begin
        e_tag = fly[i].tag; e_data = fly[i].data; e_known = fly[i].known;
      end
    end
    e_resp = '0;
    if (rst && (cmd == STORE || (cmd == LOAD && fly.size() < M0))) begin
      for (int t = 15; t >= 1; t--) begin
        if (((busy >> t) & 1) == 0) e_resp = 4'(t);
      end
    end
  endtask

  task automatic sample0();
    @(negedge clock);
    chk("resp", {60'd0, r0}, {60'd0, e_resp});
    chk("ret_tag", {60'd0, t0}, {60'd0, e_tag});
    if (e_known) chk("ret_data", q0, e_data);
  endtask

  task automatic advance0();
    ld_t n;
    int  w;
    @(posedge clock);
    w = widx(p_addr);
    if (!p_rst) fly.delete();
    else begin
      for (int i = fly.size() - 1; i >= 0; i--) if (fly[i].due == cyc) fly.delete(i);
      if (e_resp != 0 && p_cmd == LOAD) begin
        n.due = cyc + L0; n.tag = e_resp;
        n.known = mmem.exists(w);
        n.data = n.known ? mmem[w] : '0;
        fly.push_back(n);
      end else if (e_resp != 0 && p_cmd == STORE) begin
        mmem[w] = p_data;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic tick(input logic [1:0] cmd, input logic [63:0] addr,
                      input logic [63:0] data, input logic rst);
    drive0(cmd, addr, data, rst);
    sample0();
    advance0();
  endtask

  initial begin
    logic [12:0] pool [6];
    logic [1:0]  cmds5 [8];
    logic [3:0]  resp5 [8];
    logic [3:0]  rtag5 [8];
    logic [63:0] ra;
    logic [63:0] k4;
    pool  = '{13'h020, 13'h001, 13'h1FFF, 13'h0AA, 13'h555, 13'h800};
    cmds5 = '{LOAD, LOAD, LOAD, STORE, NONE, NONE, NONE, NONE};
    resp5 = '{4'd1, 4'd2, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
    rtag5 = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0};
    k4 = 64'h0123_4567_89AB_CDEF;
    checks = 0; errors = 0; cyc = 0;
    rstn = 1'b0;
    c0 = NONE; c1 = NONE; c2 = NONE;
    a0 = '0; a1 = '0; a2 = '0; d0 = '0; d1 = '0; d2 = '0;
    @(posedge clock); #1;

    // Reset held with LOAD driven on every instance
    c1 = LOAD; c2 = LOAD; a1 = 64'h100; a2 = 64'h100;
    repeat (2) begin
      drive0(LOAD, 64'h100, 64'h0, 1'b0);
      sample0();
      chk("rst_resp", {60'd0, r0}, 64'd0);
      chk("rst_tag", {60'd0, t0}, 64'd0);
      chk("rst_data", q0, 64'd0);
      chk("rst_resp_u1", {60'd0, r1}, 64'd0);
      chk("rst_resp_u2", {60'd0, r2}, 64'd0);
      advance0();
    end
    c1 = NONE; c2 = NONE;

    foreach (pool[k]) tick(STORE, {48'd0, pool[k], 3'd0}, {$urandom(), $urandom()}, 1'b1);

    // Store then load of the same word
    tick(STORE, 64'h100, 64'hDEADBEEF_CAFEF00D, 1'b1);
    drive0(LOAD, 64'h100, 64'h0, 1'b1);
    sample0();
    chk("t2_load_resp", {60'd0, r0}, 64'd1);
    advance0();
    repeat (3) tick(NONE, 64'h0, 64'h0, 1'b1);
    drive0(NONE, 64'h0, 64'h0, 1'b1);
    sample0();
    chk("t2_ret_tag", {60'd0, t0}, 64'd1);
    chk("t2_ret_data", q0, 64'hDEADBEEF_CAFEF00D);
    advance0();
    repeat (4) tick(NONE, 64'h0, 64'h0, 1'b1);

    // Load captures data before a following store
    drive0(LOAD, 64'h100, 64'h0, 1'b1);
    sample0();
    chk("t3_load_resp", {60'd0, r0}, 64'd1);
    advance0();
    tick(STORE, 64'h100, 64'h5, 1'b1);
    repeat (2) tick(NONE, 64'h0, 64'h0, 1'b1);
    drive0(NONE, 64'h0, 64'h0, 1'b1);
    sample0();
    chk("t3_ret_tag", {60'd0, t0}, 64'd1);
    chk("t3_ret_data", q0, 64'hDEADBEEF_CAFEF00D);
    advance0();
    tick(LOAD, 64'h100, 64'h0, 1'b1);
    repeat (5) tick(NONE, 64'h0, 64'h0, 1'b1);

    // Tag exhaustion and reissue on the LATENCY=15 instance
    c1 = STORE; a1 = 64'h40; d1 = k4;
    drive0(NONE, 64'h0, 64'h0, 1'b1);
    sample0();
    chk("t4_store_resp", {60'd0, r1}, 64'd1);
    advance0();
    c1 = LOAD;
    for (int k = 0; k <= 16; k++) begin
      drive0(NONE, 64'h0, 64'h0, 1'b1);
      sample0();
      chk("t4_resp", {60'd0, r1}, (k < 15) ? 64'(k + 1) : (k == 15) ? 64'd0 : 64'd1);
      chk("t4_tag", {60'd0, t1}, (k == 15) ? 64'd1 : (k == 16) ? 64'd2 : 64'd0);
      chk("t4_data", q1, (k >= 15) ? k4 : 64'd0);
      advance0();
    end
    c1 = NONE;

    // Outstanding-load limit of 2
    a2 = 64'h80; d2 = 64'h77;
    for (int k = 0; k < 8; k++) begin
      c2 = cmds5[k];
      drive0(NONE, 64'h0, 64'h0, 1'b1);
      sample0();
      chk("t5_resp", {60'd0, r2}, {60'd0, resp5[k]});
      chk("t5_tag", {60'd0, t2}, {60'd0, rtag5[k]});
      advance0();
    end
    c2 = NONE;

    // Reset drops in-flight loads
    repeat (3) tick(LOAD, 64'h100, 64'h0, 1'b1);
    tick(NONE, 64'h0, 64'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive0(NONE, 64'h0, 64'h0, 1'b1);
      sample0();
      chk("t6_no_ret", {60'd0, t0}, 64'd0);
      advance0();
    end
    drive0(LOAD, 64'h100, 64'h0, 1'b1);
    sample0();
    chk("t6_resp", {60'd0, r0}, 64'd1);
    advance0();

    // Randomized traffic, including address wrap and occasional reset
    for (int n = 0; n < 400; n++) begin
      ra = {$urandom(), $urandom()};
      ra[15:3] = pool[$urandom_range(0, 5)];
      tick(2'($urandom_range(0, 3)), ra, {$urandom(), $urandom()},
           ($urandom_range(0, 49) != 0));
    end
    repeat (6) tick(NONE, 64'h0, 64'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
